alu_script_sequencer: RTL

Parametrised, programmable stimulus sequencer for the register-file/ALU datapath. It generalises the fixed four-state bring-up FSM:
- A loadable instruction store of DEPTH words replaces the hard-coded state list.
- Each word drives destination, source, opcode, immediate and immediate-select for one cycle.
- A start/busy/done handshake controls execution.
- A stop request is supported, with optional looping.

It sits between the board-level control logic and `RegFile_Alu`, driving that block's control inputs directly.

---
 rtl/alu_script_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_script_sequencer.sv
// Programmable stimulus sequencer driving RegFile_Alu control inputs.
// Optional feature macro: SEQ_LOOP_EN (wrap to pc=0 after the last word while loop=1).
module alu_script_sequencer #(
   parameter int DEPTH = 16,
   parameter int IMM_W = 16,
   parameter int RA_W  = 4,
   parameter int OP_W  = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int IW   = 2 + OP_W + 2 * RA_W + IMM_W
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            prog_we,
   input  logic [AW-1:0]   prog_addr,
   input  logic [IW-1:0]   prog_data,
   input  logic            start,
   input  logic            stop,
   input  logic            loop,
   output logic [RA_W-1:0] RdestRegLoc,
   output logic [RA_W-1:0] RsrcRegLoc,
   output logic [OP_W-1:0] OpCode,
   output logic [IMM_W-1:0] Imm,
   output logic            Imm_s,
   output logic            En,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   pc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [IW-1:0]   mem_q [DEPTH];
   logic [IW-1:0]   mem_d [DEPTH];
   logic [RA_W-1:0] rdest_q, rdest_d;
   logic [RA_W-1:0] rsrc_q, rsrc_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [IMM_W-1:0] imm_q, imm_d;
   logic            imm_s_q, imm_s_d;
   logic            en_q, en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [IW-1:0]   word;
   logic            w_last;
   logic            at_end;
   logic            loop_act;

`ifdef SEQ_LOOP_EN
   assign loop_act = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_act    = 1'b0;
`endif

   assign word   = mem_q[pc_q];
   assign w_last = word[IW-1];
   assign at_end = w_last || (pc_q == AW'(DEPTH - 1));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mem_d   = mem_q;
      rdest_d = rdest_q;
      rsrc_d  = rsrc_q;
      op_d    = op_q;
      imm_d   = imm_q;
      imm_s_d = imm_s_q;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      // Program writes only land while idle.
      if (state_q == S_IDLE && prog_we)
         mem_d[prog_addr] = prog_data;

      case (state_q)
         S_IDLE: begin
            pc_d = '0;
            if (start)
               state_d = S_RUN;
         end
         S_RUN: begin
            imm_s_d = word[IW-2];
            op_d    = word[IW-3 -: OP_W];
            rdest_d = word[IMM_W+2*RA_W-1 -: RA_W];
            rsrc_d  = word[IMM_W+RA_W-1 -: RA_W];
            imm_d   = word[IMM_W-1:0];
            en_d    = 1'b1;
            busy_d  = 1'b1;
            if (stop) begin
               state_d = S_DONE;
               pc_d    = '0;
            end else if (at_end) begin
               pc_d = '0;
               if (!loop_act)
                  state_d = S_DONE;
            end else begin
               pc_d = pc_q + AW'(1);
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            pc_d    = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         rdest_q <= '0;
         rsrc_q  <= '0;
         op_q    <= '0;
         imm_q   <= '0;
         imm_s_q <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rdest_q <= rdest_d;
         rsrc_q  <= rsrc_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         imm_s_q <= imm_s_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
      end
   end

   assign RdestRegLoc = rdest_q;
   assign RsrcRegLoc  = rsrc_q;
   assign OpCode      = op_q;
   assign Imm         = imm_q;
   assign Imm_s       = imm_s_q;
   assign En          = en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pc          = pc_q;

endmodule
